// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - writeback arbiter merging ALU results and buffered loads into one bank write port
//
// Purpose:
//    Merges ALU writebacks (priority) and load writebacks (queued in a small
//    FIFO) into a single registered write port. A younger ALU write kills
//    every queued load to the same register, so stale load data never
//    overwrites it. A head entry that has waited STARVE_LIMIT cycles
//    preempts the ALU for one cycle.
//
// Ports:
//    CLK, RST              clock, synchronous active-high reset
//    alu_valid/rd/data     ALU writeback request; alu_ready accepts it
//    ld_valid/rd/data      load writeback request; ld_ready accepts it
//    wdat, en              registered bank write data and one-hot enable
//    pending               registers targeted by live (non-killed) queued loads
//    fifo_count            load FIFO occupancy
module wb_write_arbiter #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [WIDTH-1:0]         alu_data,
   output logic                     alu_ready,
   input  logic                     ld_valid,
   input  logic [4:0]               ld_rd,
   input  logic [WIDTH-1:0]         ld_data,
   output logic                     ld_ready,
   output logic [WIDTH-1:0]         wdat,
   output logic [31:0]              en,
   output logic [31:0]              pending,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]       q_rd   [DEPTH];
   logic [WIDTH-1:0] q_data [DEPTH];
   logic [DEPTH-1:0] q_kill;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic [SW-1:0]    starve_cnt;

   logic head_present;
   logic head_kill;
   logic force_head;
   logic alu_wr;
   logic ld_enq;
   logic pop;
   logic head_write;

   assign fifo_count   = count;
   assign head_present = (count != '0);
   assign head_kill    = q_kill[rd_ptr];
   assign force_head   = head_present && !head_kill && (starve_cnt >= SW'(STARVE_LIMIT));
   assign alu_ready    = !force_head && !RST;
   assign ld_ready     = (count < CW'(DEPTH)) && !RST;

   // rd=0 requests are accepted but never written or queued
   assign alu_wr     = alu_valid && alu_ready && (alu_rd != 5'd0);
   assign ld_enq     = ld_valid && ld_ready && (ld_rd != 5'd0);

   // A killed head is discarded regardless of ALU activity; a live head
   // only leaves when the port is free.
   assign pop        = head_present && (head_kill || !alu_wr);
   assign head_write = pop && !head_kill;

   // An entry is occupied when its distance from the head is below count
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, AW'(AW'(i) - rd_ptr)} < count) && !q_kill[i]) begin
            pending[q_rd[i]] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         en         <= '0;
         wdat       <= '0;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         q_kill     <= '0;
         starve_cnt <= '0;
      end else begin
         if (alu_wr) begin
            en   <= 32'd1 << alu_rd;
            wdat <= alu_data;
         end else if (head_write) begin
            en   <= 32'd1 << q_rd[rd_ptr];
            wdat <= q_data[rd_ptr];
         end else begin
            en   <= '0;
         end

         // Kill older loads to the register the ALU is overwriting; stale
         // slots may also be marked, which is harmless since enqueue rewrites kill.
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_wr && (q_rd[i] == alu_rd)) begin
               q_kill[i] <= 1'b1;
            end
         end

         if (ld_enq) begin
            q_rd[wr_ptr]   <= ld_rd;
            q_data[wr_ptr] <= ld_data;
            q_kill[wr_ptr] <= alu_wr && (ld_rd == alu_rd);
            wr_ptr         <= wr_ptr + 1'b1;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         if (ld_enq && !pop) begin
            count <= count + 1'b1;
         end else if (!ld_enq && pop) begin
            count <= count - 1'b1;
         end

         if (pop || !head_present) begin
            starve_cnt <= '0;
         end else if (!head_kill && (starve_cnt < SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - scoreboard bench for wb_write_arbiter
module tb_wb_write_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        alu_ready;
   logic        ld_valid = 1'b0;
   logic [4:0]  ld_rd = '0;
   logic [31:0] ld_data = '0;
   logic        ld_ready;
   logic [31:0] wdat;
   logic [31:0] en;
   logic [31:0] pending;
   logic [1:0]  fifo_count;

   int tests = 0;
   int fails = 0;
   logic [63:0] exp_q[$];

   wb_write_arbiter dut (
      .CLK(CLK), .RST(RST),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .wdat(wdat), .en(en), .pending(pending), .fifo_count(fifo_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] e, input logic [31:0] d);
      exp_q.push_back({e, d});
   endtask

   // drive one cycle's inputs just after the edge, return at the following negedge
   task automatic cyc(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      @(posedge CLK);
      #1;
      RST = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
      ld_valid = lv; ld_rd = lrd; ld_data = ld;
      @(negedge CLK);
   endtask

   // monitor: every bank write must match the next expected write
   initial begin
      logic [63:0] e;
      @(posedge CLK);
      forever begin
         @(negedge CLK);
         if (en != 32'd0) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got en=%h wdat=%h expected no write", en, wdat);
            end else begin
               e = exp_q.pop_front();
               check("write_en", en, e[63:32]);
               check("write_data", wdat, e[31:0]);
            end
         end
      end
   end

   initial begin
      // reset with requests asserted
      cyc(1, 1, 5'd4, 32'h44, 1, 5'd4, 32'h55);
      cyc(1, 1, 5'd4, 32'h44, 1, 5'd4, 32'h55);
      check("rst_en", en, 32'h0);
      check("rst_wdat", wdat, 32'h0);
      check("rst_pending", pending, 32'h0);
      check("rst_count", {30'd0, fifo_count}, 32'd0);
      check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
      check("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("post_rst_en", en, 32'h0);

      // ALU path
      push(32'h20, 32'hDEADBEEF);
      cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("alu_en_n1", en, 32'h20);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("alu_en_n2", en, 32'h0);

      // load path
      push(32'h8, 32'h1234);
      cyc(0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h1234);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("ld_pending_n1", pending, 32'h8);
      check("ld_count_n1", {30'd0, fifo_count}, 32'd1);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("ld_pending_n2", pending, 32'h0);
      check("ld_en_n2", en, 32'h8);

      // starvation and full FIFO
      push(32'h2, 32'h101);
      cyc(0, 1, 5'd1, 32'h101, 1, 5'd9, 32'h900);
      push(32'h4, 32'h102);
      cyc(0, 1, 5'd2, 32'h102, 1, 5'd10, 32'hA00);
      push(32'h8, 32'h103);
      cyc(0, 1, 5'd3, 32'h103, 1, 5'd11, 32'hB00);
      check("full_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("full_count", {30'd0, fifo_count}, 32'd2);
      check("full_pending", pending, 32'h600);
      push(32'h10, 32'h104);
      cyc(0, 1, 5'd4, 32'h104, 1, 5'd11, 32'hB00);
      check("starve3_alu_ready", {31'd0, alu_ready}, 32'd1);
      push(32'h20, 32'h105);
      cyc(0, 1, 5'd5, 32'h105, 1, 5'd11, 32'hB00);
      check("starve4_alu_ready", {31'd0, alu_ready}, 32'd1);
      push(32'h200, 32'h900);
      cyc(0, 1, 5'd6, 32'h106, 1, 5'd11, 32'hB00);
      check("force_alu_ready", {31'd0, alu_ready}, 32'd0);
      check("force_ld_ready", {31'd0, ld_ready}, 32'd0);
      push(32'h40, 32'h106);
      cyc(0, 1, 5'd6, 32'h106, 1, 5'd11, 32'hB00);
      check("force_en", en, 32'h200);
      check("retry_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("retry_ld_ready", {31'd0, ld_ready}, 32'd1);
      push(32'h400, 32'hA00);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("drain_count2", {30'd0, fifo_count}, 32'd2);
      push(32'h800, 32'hB00);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("drain_count1", {30'd0, fifo_count}, 32'd1);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("drain_count0", {30'd0, fifo_count}, 32'd0);

      // kill: queued rd7 load overtaken by younger ALU rd7 write
      push(32'h2, 32'h11);
      cyc(0, 1, 5'd1, 32'h11, 1, 5'd12, 32'hC00);
      push(32'h4, 32'h22);
      cyc(0, 1, 5'd2, 32'h22, 1, 5'd7, 32'hAAAA);
      push(32'h80, 32'hBBBB);
      cyc(0, 1, 5'd7, 32'hBBBB, 0, 5'd0, 32'h0);
      check("kill_pending_before", pending, 32'h1080);
      push(32'h1000, 32'hC00);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("kill_pending_after", pending, 32'h1000);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("kill_pending_head", pending, 32'h0);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("kill_no_write", en, 32'h0);
      check("kill_count", {30'd0, fifo_count}, 32'd0);

      // rd=0 on both paths
      cyc(0, 0, 5'd0, 32'h0, 1, 5'd13, 32'hD00);
      push(32'h2000, 32'hD00);
      cyc(0, 1, 5'd0, 32'h5555, 0, 5'd0, 32'h0);
      check("rd0_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("rd0_count1", {30'd0, fifo_count}, 32'd1);
      cyc(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h77);
      check("rd0_ld_ready", {31'd0, ld_ready}, 32'd1);
      check("rd0_count0", {30'd0, fifo_count}, 32'd0);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("ld_rd0_count", {30'd0, fifo_count}, 32'd0);
      check("ld_rd0_en", en, 32'h0);

      // reset mid-operation with two queued loads
      push(32'h2, 32'h1);
      cyc(0, 1, 5'd1, 32'h1, 1, 5'd14, 32'hE00);
      push(32'h4, 32'h2);
      cyc(0, 1, 5'd2, 32'h2, 1, 5'd15, 32'hF00);
      cyc(1, 1, 5'd3, 32'h3, 0, 5'd0, 32'h0);
      check("mid_rst_count_before", {30'd0, fifo_count}, 32'd2);
      check("mid_rst_pending_before", pending, 32'hC000);
      check("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("mid_rst_count", {30'd0, fifo_count}, 32'd0);
      check("mid_rst_pending", pending, 32'h0);
      check("mid_rst_en", en, 32'h0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      check("writes_outstanding", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-side front end of the register bank; sits directly upstream of it.
- Merges two writeback sources into the bank's single write port (wdat plus one-hot en[31:0]):
  - ALU results, which have priority.
  - Load data, which is buffered in a small FIFO.
- Guarantees program-order correctness when a younger ALU write targets a register that has a queued load.
- Exports a pending-write mask for hazard logic.

Parameters:
- WIDTH, 32, data width of register writes.
- DEPTH, 2, load FIFO entries (power of 2, at least 2).
- STARVE_LIMIT, 4, cycles a non-killed FIFO head may wait before it preempts the ALU.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; synchronous, active-high.
- alu_valid  input  1  ALU writeback request.
- alu_rd  input  5  ALU destination register.
- alu_data  input  WIDTH  ALU result.
- alu_ready  output  1  ALU request accepted this cycle when alu_valid && alu_ready.
- ld_valid  input  1  load writeback request.
- ld_rd  input  5  load destination register.
- ld_data  input  WIDTH  load data.
- ld_ready  output  1  load request accepted when ld_valid && ld_ready.
- wdat  output  WIDTH  registered write data to the register bank.
- en  output  32  registered one-hot write enable to the bank; all-zero means no write; bit 0 never set.
- pending  output  32  bit r set iff a non-killed FIFO entry targets r; combinational from state.
- fifo_count  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RST high at edge):
  - en=0, wdat=0, FIFO emptied (count=0, all kill bits clear), starve_cnt=0.
  - alu_ready=0 and ld_ready=0 while RST is high; requests in those cycles are ignored.
  - Applies mid-operation: queued loads are discarded, and en=0 on the following cycle.
- ld_ready = (count < DEPTH) && !RST; it does not account for a same-cycle dequeue.
- Load accept: the entry {rd, data, kill=0} is enqueued at the tail.
  - ld_rd=0 is accepted and discarded; not enqueued.
  - No bypass: the earliest dequeue is the next cycle.
- force = (count>0) && (head not killed) && (starve_cnt >= STARVE_LIMIT).
- alu_ready = !force && !RST.
- Write select each cycle, at most one write:
  - 1) ALU accepted with alu_rd!=0: en_next = 1<<alu_rd, wdat_next = alu_data.
  - 2) Else, head present and not killed: en_next = 1<<head.rd, wdat_next = head.data; pop head.
  - 3) Else: en_next = 0; wdat holds its previous value.
  - An ALU write to rd=0 is accepted, produces no write, and frees the port for the FIFO head.
- Killed head: popped in the same cycle regardless of ALU activity; produces no write.
- Kill rule: when an ALU write to rd!=0 is accepted, every FIFO entry with rd == alu_rd gets kill=1 at that edge, including an entry enqueued in the same cycle.
  - Such a load is older and must not overwrite the younger ALU value.
- Same-cycle enqueue and pop: both take effect; count is unchanged.
- starve_cnt:
  - Clears on a pop, or when the FIFO is empty.
  - Otherwise increments each cycle the head is present, not killed, and not popped.
  - Saturates at STARVE_LIMIT.
- Latency:
  - ALU accept in cycle N gives en/wdat in cycle N+1; the bank captures at the end of N+1.
  - Uncontended load accept in N gives pending bit set in N+1, en in N+2, and the pending bit clears in N+2.
- FIFO pointers wrap modulo DEPTH; count never exceeds DEPTH.

Test Plan:
- Reset: hold RST 2 cycles with alu_valid=1 and ld_valid=1 → en=0, wdat=0, pending=0, fifo_count=0, both readies 0. Release → ld_ready=1, alu_ready=1.
- ALU path: alu_rd=5, alu_data=0xDEADBEEF in cycle N → en=0x00000020 and wdat=0xDEADBEEF in N+1; en=0 in N+2.
- Load path: ld_rd=3, ld_data=0x1234 in N, ALU idle → pending=0x8 and fifo_count=1 in N+1; en=0x8 and wdat=0x1234 in N+2; pending=0 in N+2.
- Starvation/full: alu_valid=1 every cycle (rd=1..), loads to rd 9 then 10.
  - fifo_count=2, ld_ready=0, and a third load is held.
  - Head to rd 9 waits 4 cycles, then alu_ready=0 for one cycle and en=0x200 next cycle.
  - The ALU request is retried and written one cycle later.
- Kill: load rd=7 data=0xAAAA queued behind a starving head, then ALU rd=7 data=0xBBBB accepted.
  - en=0x80 with wdat=0xBBBB; pending bit 7 clears at that edge.
  - On pop, the rd-7 entry produces no en; 0xAAAA never appears on wdat.
- rd=0 and reset mid-operation:
  - ALU rd=0 with a queued load → no en bit 0; the load is written that cycle.
  - Load rd=0 → fifo_count unchanged.
  - RST with 2 queued loads → next cycle fifo_count=0, pending=0, en=0.
